// File: rtl/div_if.sv
// div_if: handshake/operand bundle between the EX stage and the divider.
//
// Valid/ready semantics: EX raises start_i with the operands and keeps it
// high until it has seen ready_o; result_o is valid exactly while ready_o is
// high. Dropping start_i while ready_o is high consumes the result, and the
// divider then returns to idle. annul_i aborts an in-flight operation.
//
// Signals:
//   signed_div_i  1 = DIV (two's complement), 0 = DIVU
//   opdata1_i     dividend
//   opdata2_i     divisor
//   start_i       division request, level-held until the result is consumed
//   annul_i       abort (pipeline flush)
//   result_o      {remainder, quotient}
//   ready_o       result_o valid
//   state_dbg     current FSM state encoding (observation only)
interface div_if #(
    parameter int DATA_W = 32
);
    logic                  signed_div_i;
    logic [DATA_W-1:0]     opdata1_i;
    logic [DATA_W-1:0]     opdata2_i;
    logic                  start_i;
    logic                  annul_i;
    logic [2*DATA_W-1:0]   result_o;
    logic                  ready_o;
    logic [1:0]            state_dbg;

    modport master (
        output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        input  result_o, ready_o, state_dbg
    );

    modport slave (
        input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        output result_o, ready_o, state_dbg
    );
endinterface

// File: rtl/div_unit.sv
// div_unit: multi-cycle radix-2 restoring divider for the EX stage (DIV/DIVU).
//
// One quotient bit is produced per cycle. Signed operands are converted to
// magnitudes on entry and the signs are fixed up once the iteration ends.
// result_o = {remainder, quotient}; ready_o rises DATA_W+1 edges after the
// edge that accepted start_i.
//
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous reset, active-high
//   bus   div_if.slave (operands, start/annul, result/ready, state_dbg)
//
// Build option: define DIV_ZERO_FAST_EN to add the BYZERO state, which
// answers a zero divisor with result_o = 0 two edges after start instead of
// running the full iteration.
module div_unit #(
    parameter int DATA_W = 32
) (
    input  logic  clk,
    input  logic  rst,
    div_if.slave  bus
);

    localparam int CNT_W = $clog2(DATA_W);

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BYZERO = 2'd1,
        ON     = 2'd2,
        END    = 2'd3
    } state_t;

    state_t              state;
    state_t              state_nxt;

    logic [DATA_W-1:0]   dvd;        // dividend in, quotient shifted in from the LSB
    logic [DATA_W-1:0]   divisor;
    logic [DATA_W-1:0]   rem;
    logic [CNT_W-1:0]    cnt;
    logic                iter_done;  // all DATA_W quotient bits produced
    logic                neg_quo;
    logic                neg_rem;
    logic [2*DATA_W-1:0] result;
    logic                ready;

    logic                accept;
    logic                op1_neg;
    logic                op2_neg;
    logic [DATA_W-1:0]   shifted;
    logic [DATA_W:0]     trial;
    logic                borrow;
    logic [DATA_W-1:0]   quo_fix;
    logic [DATA_W-1:0]   rem_fix;

    assign bus.result_o  = result;
    assign bus.ready_o   = ready;
    assign bus.state_dbg = state;

    assign accept  = bus.start_i && !bus.annul_i;
    assign op1_neg = bus.signed_div_i && bus.opdata1_i[DATA_W-1];
    assign op2_neg = bus.signed_div_i && bus.opdata2_i[DATA_W-1];

    // Before each shift the partial remainder holds at most DATA_W-1
    // significant bits, so dropping its MSB in the shift loses nothing.
    assign shifted = {rem[DATA_W-2:0], dvd[DATA_W-1]};
    assign trial   = {1'b0, shifted} - {1'b0, divisor};
    assign borrow  = trial[DATA_W];

    assign quo_fix = neg_quo ? (~dvd + 1'b1) : dvd;
    assign rem_fix = neg_rem ? (~rem + 1'b1) : rem;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FREE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            FREE: begin
                if (accept) begin
                    state_nxt = ON;
`ifdef DIV_ZERO_FAST_EN
                    if (bus.opdata2_i == '0) begin
                        state_nxt = BYZERO;
                    end
`endif
                end
            end
`ifdef DIV_ZERO_FAST_EN
            BYZERO: state_nxt = END;
`endif
            ON: begin
                if (bus.annul_i) begin
                    state_nxt = FREE;
                end else if (iter_done) begin
                    state_nxt = END;
                end
            end
            END: begin
                // annul_i is deliberately ignored here: the result is final.
                if (!bus.start_i) begin
                    state_nxt = FREE;
                end
            end
            default: state_nxt = FREE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dvd       <= '0;
            divisor   <= '0;
            rem       <= '0;
            cnt       <= '0;
            iter_done <= 1'b0;
            neg_quo   <= 1'b0;
            neg_rem   <= 1'b0;
            result    <= '0;
            ready     <= 1'b0;
        end else begin
            case (state)
                FREE: begin
                    result <= '0;
                    ready  <= 1'b0;
                    if (accept) begin
                        dvd       <= op1_neg ? (~bus.opdata1_i + 1'b1) : bus.opdata1_i;
                        divisor   <= op2_neg ? (~bus.opdata2_i + 1'b1) : bus.opdata2_i;
                        neg_quo   <= op1_neg ^ op2_neg;
                        neg_rem   <= op1_neg;
                        rem       <= '0;
                        cnt       <= '0;
                        iter_done <= 1'b0;
                    end
                end
`ifdef DIV_ZERO_FAST_EN
                BYZERO: begin
                    result <= '0;
                end
`endif
                ON: begin
                    if (!bus.annul_i) begin
                        if (!iter_done) begin
                            rem <= borrow ? shifted : trial[DATA_W-1:0];
                            dvd <= {dvd[DATA_W-2:0], ~borrow};
                            cnt <= cnt + CNT_W'(1);
                            if (cnt == CNT_W'(DATA_W - 1)) begin
                                iter_done <= 1'b1;
                            end
                        end else begin
                            result <= {rem_fix, quo_fix};
                            ready  <= 1'b1;
                        end
                    end
                end
                END: begin
                    if (bus.start_i) begin
                        ready <= 1'b1;
                    end else begin
                        ready  <= 1'b0;
                        result <= '0;
                    end
                end
                default: begin
                    ready  <= 1'b0;
                    result <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
module tb_div_unit;

  localparam int DATA_W = 32;

`ifdef DIV_ZERO_FAST_EN
  localparam int ZERO_LAT = 2;
  localparam logic [63:0] ZERO_RES = 64'h0;
`else
  localparam int ZERO_LAT = 33;
  localparam logic [63:0] ZERO_RES = 64'h00000005_FFFFFFFF;
`endif

  typedef struct {
    string       name;
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp_res;
    int          lat;
  } vec_t;

  logic clk = 1'b0;
  logic rst;

  int n_checks = 0;
  int n_pass   = 0;

  vec_t vecs[$];

  div_if #(.DATA_W(DATA_W)) bus ();

  div_unit #(.DATA_W(DATA_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard check
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    n_checks++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp_v);
  endtask

  // driver: one full division handshake with result hold and consume
  task automatic run_div(input vec_t v, input bit scramble);
    int cyc;
    logic [63:0] held;
    @(negedge clk);
    bus.signed_div_i = v.sgn;
    bus.opdata1_i    = v.a;
    bus.opdata2_i    = v.b;
    bus.start_i      = 1'b1;
    cyc = 0;
    do begin
      @(posedge clk);
      #1;
      cyc++;
      if (scramble && cyc == 5) begin
        bus.opdata1_i    = 32'hDEAD_BEEF;
        bus.opdata2_i    = 32'h0000_0003;
        bus.signed_div_i = ~v.sgn;
      end
    end while (!bus.ready_o && cyc < 100);
    check({v.name, " latency"}, 64'(cyc - 1), 64'(v.lat));
    check({v.name, " result"}, bus.result_o, v.exp_res);
    held = bus.result_o;
    // annul during END must be ignored
    @(negedge clk);
    bus.annul_i = 1'b1;
    @(negedge clk);
    bus.annul_i = 1'b0;
    #1;
    check({v.name, " hold"}, {bus.ready_o, bus.result_o[62:0]}, {1'b1, held[62:0]});
    @(negedge clk);
    bus.start_i = 1'b0;
    @(posedge clk);
    #1;
    check({v.name, " release"}, {63'd0, bus.ready_o} | bus.result_o, 64'h0);
  endtask

  initial begin
    int hi_seen;
    vec_t v;

    vecs.push_back('{"divu_100_7",     1'b0, 32'd100,       32'd7,         64'h00000002_0000000E, 33});
    vecs.push_back('{"div_m7_2",       1'b1, 32'hFFFFFFF9,  32'd2,         64'hFFFFFFFF_FFFFFFFD, 33});
    vecs.push_back('{"div_ovf",        1'b1, 32'h80000000,  32'hFFFFFFFF,  64'h00000000_80000000, 33});
    vecs.push_back('{"divu_max_1",     1'b0, 32'hFFFFFFFF,  32'd1,         64'h00000000_FFFFFFFF, 33});
    vecs.push_back('{"div_7_m2",       1'b1, 32'd7,         32'hFFFFFFFE,  64'h00000001_FFFFFFFD, 33});
    vecs.push_back('{"div_m7_m2",      1'b1, 32'hFFFFFFF9,  32'hFFFFFFFE,  64'hFFFFFFFF_00000003, 33});
    vecs.push_back('{"divu_hex",       1'b0, 32'h12345678,  32'h00000100,  64'h00000078_00123456, 33});
    vecs.push_back('{"divu_small_q",   1'b0, 32'h80000000,  32'h80000001,  64'h80000000_00000000, 33});
    vecs.push_back('{"divu_max_max",   1'b0, 32'hFFFFFFFF,  32'hFFFFFFFF,  64'h00000000_00000001, 33});
    vecs.push_back('{"divu_0_5",       1'b0, 32'd0,         32'd5,         64'h00000000_00000000, 33});
    vecs.push_back('{"divu_5_0",       1'b0, 32'd5,         32'd0,         ZERO_RES,              ZERO_LAT});

    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = '0;
    bus.opdata2_i    = '0;
    bus.start_i      = 1'b0;
    bus.annul_i      = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset outputs", {61'd0, bus.state_dbg, bus.ready_o} | bus.result_o, 64'h0);
    @(negedge clk);
    rst = 1'b0;

    // table-driven vectors
    foreach (vecs[i]) run_div(vecs[i], 1'b0);

    // operand changes during ON are ignored
    v = vecs[0];
    v.name = "scramble_100_7";
    run_div(v, 1'b1);

    // annul in FREE suppresses start
    @(negedge clk);
    bus.opdata1_i = 32'd50;
    bus.opdata2_i = 32'd5;
    bus.start_i   = 1'b1;
    bus.annul_i   = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("annul in FREE", {62'd0, bus.state_dbg}, 64'h0);
    @(negedge clk);
    bus.start_i = 1'b0;
    bus.annul_i = 1'b0;

    // abort on the 10th ON cycle
    @(negedge clk);
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'd1000;
    bus.opdata2_i    = 32'd3;
    bus.start_i      = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    bus.annul_i = 1'b1;
    bus.start_i = 1'b0;
    @(negedge clk);
    bus.annul_i = 1'b0;
    hi_seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (bus.ready_o !== 1'b0 || bus.result_o !== 64'h0) hi_seen++;
    end
    check("abort quiet", 64'(hi_seen), 64'h0);
    run_div('{"after_abort_9_3", 1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 33}, 1'b0);

    // async reset mid-ON
    @(negedge clk);
    bus.opdata1_i = 32'd100;
    bus.opdata2_i = 32'd7;
    bus.start_i   = 1'b1;
    repeat (15) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async reset mid-ON", {61'd0, bus.state_dbg, bus.ready_o} | bus.result_o, 64'h0);
    @(negedge clk);
    bus.start_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    run_div(vecs[0], 1'b0);

    // async reset while a result is being held
    @(negedge clk);
    bus.opdata1_i = 32'd100;
    bus.opdata2_i = 32'd7;
    bus.start_i   = 1'b1;
    repeat (36) @(posedge clk);
    #1;
    check("pre-reset END ready", {63'd0, bus.ready_o}, 64'h1);
    #2;
    rst = 1'b1;
    #1;
    check("async reset in END", {61'd0, bus.state_dbg, bus.ready_o} | bus.result_o, 64'h0);
    @(negedge clk);
    bus.start_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    run_div(vecs[1], 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
